// File: rtl/writeback_arbiter_pkg.sv
// Shared source encodings and payload type for the register-file writeback arbiter.
package writeback_arbiter_pkg;

  localparam int AGE_W = 4;

  typedef enum logic [1:0] {
    SRC_INT  = 2'd0,
    SRC_FPU  = 2'd1,
    SRC_FFT  = 2'd2,
    SRC_NONE = 2'd3
  } wbSrc_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        isFp;
  } wbPayload_t;

endpackage

// File: rtl/writeback_arbiter_wb_age_counter.sv
// Saturating wait-age counter; flags when a losing source has waited LIMIT cycles.
module wb_age_counter
  import writeback_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic atLimit_o
);

  localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(LIMIT);

  logic [AGE_W-1:0] count_q;
  logic [AGE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT_C)) begin
      count_d = count_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign atLimit_o = (count_q == LIMIT_C);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges integer-pipe, FP-unit and FFT-store results onto the single register-file
// write port using priority, round-robin and anti-starvation aging.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_valid,
  output logic             int_ready,
  input  logic [4:0]       int_rd,
  input  logic [31:0]      int_data,
  input  logic             int_is_fp,
  input  logic             fpu_valid,
  output logic             fpu_ready,
  input  logic [4:0]       fpu_rd,
  input  logic [31:0]      fpu_data,
  input  logic             fpu_is_fp,
  input  logic             fft_valid,
  output logic             fft_ready,
  input  logic [4:0]       fft_rd,
  input  logic [31:0]      fft_data,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             wb_fp_reg_write,
  output logic [1:0]       wb_src,
  output logic [CNT_W-1:0] perf_conflict_cnt,
  output logic [CNT_W-1:0] perf_starve_cnt
);

  wbSrc_e     grant;
  logic       forced;
  logic       conflict;
  wbPayload_t selPl;
  logic       fpuAtLimit;
  logic       fftAtLimit;

  logic             rrPtr_q, rrPtr_d;
  logic [31:0]      wbData_q, wbData_d;
  logic [4:0]       wbRd_q, wbRd_d;
  logic             wbRegWrite_q, wbRegWrite_d;
  logic             wbFpRegWrite_q, wbFpRegWrite_d;
  wbSrc_e           wbSrc_q, wbSrc_d;
  logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

  wb_age_counter #(.LIMIT(STARVE_LIMIT)) uFpuAge (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (fpu_valid && (grant != SRC_FPU)),
    .clr_i     (!fpu_valid || (grant == SRC_FPU)),
    .atLimit_o (fpuAtLimit)
  );

  wb_age_counter #(.LIMIT(STARVE_LIMIT)) uFftAge (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (fft_valid && (grant != SRC_FFT)),
    .clr_i     (!fft_valid || (grant == SRC_FFT)),
    .atLimit_o (fftAtLimit)
  );

  // rrPtr_q: 0 names FPU, 1 names FFT for the next FPU/FFT tie.
  always_comb begin
    grant  = SRC_NONE;
    forced = 1'b0;
    if (fpuAtLimit && fpu_valid) begin
      grant  = SRC_FPU;
      forced = 1'b1;
    end else if (fftAtLimit && fft_valid) begin
      grant  = SRC_FFT;
      forced = 1'b1;
    end else if (int_valid) begin
      grant = SRC_INT;
    end else if (fpu_valid && fft_valid) begin
      grant = rrPtr_q ? SRC_FFT : SRC_FPU;
    end else if (fpu_valid) begin
      grant = SRC_FPU;
    end else if (fft_valid) begin
      grant = SRC_FFT;
    end
  end

  assign int_ready = (grant == SRC_INT);
  assign fpu_ready = (grant == SRC_FPU);
  assign fft_ready = (grant == SRC_FFT);

  assign conflict = (int_valid && (grant != SRC_INT)) ||
                    (fpu_valid && (grant != SRC_FPU)) ||
                    (fft_valid && (grant != SRC_FFT));

  always_comb begin
    selPl = '{rd: int_rd, data: int_data, isFp: int_is_fp};
    case (grant)
      SRC_FPU: selPl = '{rd: fpu_rd, data: fpu_data, isFp: fpu_is_fp};
      SRC_FFT: selPl = '{rd: fft_rd, data: fft_data, isFp: 1'b1};
      default: ;
    endcase
  end

  // Integer-file writes to x0 are consumed but never reach the register file.
  always_comb begin
    rrPtr_d        = rrPtr_q;
    wbData_d       = wbData_q;
    wbRd_d         = wbRd_q;
    wbRegWrite_d   = 1'b0;
    wbFpRegWrite_d = 1'b0;
    wbSrc_d        = SRC_NONE;
    conflictCnt_d  = conflictCnt_q;
    starveCnt_d    = starveCnt_q;
    if (grant == SRC_FPU) rrPtr_d = 1'b1;
    if (grant == SRC_FFT) rrPtr_d = 1'b0;
    if (grant != SRC_NONE) begin
      wbData_d       = selPl.data;
      wbRd_d         = selPl.rd;
      wbRegWrite_d   = selPl.isFp || (selPl.rd != 5'd0);
      wbFpRegWrite_d = selPl.isFp;
      wbSrc_d        = grant;
    end
    if (conflict && (conflictCnt_q != '1)) conflictCnt_d = conflictCnt_q + CNT_W'(1);
    if (forced && (starveCnt_q != '1)) starveCnt_d = starveCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q        <= 1'b0;
      wbData_q       <= '0;
      wbRd_q         <= '0;
      wbRegWrite_q   <= 1'b0;
      wbFpRegWrite_q <= 1'b0;
      wbSrc_q        <= SRC_NONE;
      conflictCnt_q  <= '0;
      starveCnt_q    <= '0;
    end else begin
      rrPtr_q        <= rrPtr_d;
      wbData_q       <= wbData_d;
      wbRd_q         <= wbRd_d;
      wbRegWrite_q   <= wbRegWrite_d;
      wbFpRegWrite_q <= wbFpRegWrite_d;
      wbSrc_q        <= wbSrc_d;
      conflictCnt_q  <= conflictCnt_d;
      starveCnt_q    <= starveCnt_d;
    end
  end

  assign wb_data           = wbData_q;
  assign wb_rd             = wbRd_q;
  assign wb_reg_write      = wbRegWrite_q;
  assign wb_fp_reg_write   = wbFpRegWrite_q;
  assign wb_src            = wbSrc_q;
  assign perf_conflict_cnt = conflictCnt_q;
  assign perf_starve_cnt   = starveCnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        int_valid, int_ready, int_is_fp;
  logic [4:0]  int_rd;
  logic [31:0] int_data;
  logic        fpu_valid, fpu_ready, fpu_is_fp;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        fft_valid, fft_ready;
  logic [4:0]  fft_rd;
  logic [31:0] fft_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_fp_reg_write;
  logic [1:0]  wb_src;
  logic [15:0] perf_conflict_cnt, perf_starve_cnt;

  int checkCount = 0;
  int passCount  = 0;

  writeback_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .int_valid         (int_valid),
    .int_ready         (int_ready),
    .int_rd            (int_rd),
    .int_data          (int_data),
    .int_is_fp         (int_is_fp),
    .fpu_valid         (fpu_valid),
    .fpu_ready         (fpu_ready),
    .fpu_rd            (fpu_rd),
    .fpu_data          (fpu_data),
    .fpu_is_fp         (fpu_is_fp),
    .fft_valid         (fft_valid),
    .fft_ready         (fft_ready),
    .fft_rd            (fft_rd),
    .fft_data          (fft_data),
    .wb_data           (wb_data),
    .wb_rd             (wb_rd),
    .wb_reg_write      (wb_reg_write),
    .wb_fp_reg_write   (wb_fp_reg_write),
    .wb_src            (wb_src),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_starve_cnt   (perf_starve_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ird, input logic [31:0] idat,
                               input logic ifp, input logic fv, input logic [4:0] frd,
                               input logic [31:0] fdat, input logic ffp, input logic tv,
                               input logic [4:0] trd, input logic [31:0] tdat);
    int_valid = iv;  int_rd = ird;  int_data = idat;  int_is_fp = ifp;
    fpu_valid = fv;  fpu_rd = frd;  fpu_data = fdat;  fpu_is_fp = ffp;
    fft_valid = tv;  fft_rd = trd;  fft_data = tdat;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] expSrc;
    rst = 1'b1;
    idle();
    #12;
    checkOutput("reset_src", 64'(wb_src), 64'd3);
    checkOutput("reset_we", 64'(wb_reg_write), 64'd0);
    checkOutput("reset_fpwe", 64'(wb_fp_reg_write), 64'd0);
    checkOutput("reset_data", 64'(wb_data), 64'd0);
    checkOutput("reset_conflict", 64'(perf_conflict_cnt), 64'd0);
    rst = 1'b0;

    // Single integer write, then back to idle
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("int_ready", 64'(int_ready), 64'd1);
    checkOutput("int_fpu_ready", 64'(fpu_ready), 64'd0);
    tick();
    idle();
    checkOutput("int_we", 64'(wb_reg_write), 64'd1);
    checkOutput("int_fpwe", 64'(wb_fp_reg_write), 64'd0);
    checkOutput("int_rd", 64'(wb_rd), 64'd5);
    checkOutput("int_data", 64'(wb_data), 64'hDEADBEEF);
    checkOutput("int_src", 64'(wb_src), 64'd0);
    tick();
    checkOutput("idle_we", 64'(wb_reg_write), 64'd0);
    checkOutput("idle_src", 64'(wb_src), 64'd3);
    checkOutput("idle_data_hold", 64'(wb_data), 64'hDEADBEEF);

    // FPU vs FFT contention alternates starting with FPU
    applyStimulus(0, 0, 0, 0, 1, 5'd1, 32'h11111111, 1, 1, 5'd2, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      expSrc = (i % 2 == 0) ? 2'd1 : 2'd2;
      #1;
      checkOutput("rr_fpu_ready", 64'(fpu_ready), 64'(expSrc == 2'd1));
      checkOutput("rr_fft_ready", 64'(fft_ready), 64'(expSrc == 2'd2));
      tick();
      checkOutput("rr_src", 64'(wb_src), 64'(expSrc));
      checkOutput("rr_fpwe", 64'(wb_fp_reg_write), 64'd1);
      checkOutput("rr_data", 64'(wb_data), (expSrc == 2'd1) ? 64'h11111111 : 64'h22222222);
    end
    idle();
    checkOutput("rr_conflict_cnt", 64'(perf_conflict_cnt), 64'd4);
    tick();

    // INT and FPU both valid: FPU force-granted every fifth cycle
    applyStimulus(1, 5'd3, 32'h0000000A, 0, 1, 5'd4, 32'h0000000B, 1, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      expSrc = (c == 4 || c == 9) ? 2'd1 : 2'd0;
      #1;
      checkOutput("starve_int_ready", 64'(int_ready), 64'(expSrc == 2'd0));
      checkOutput("starve_fpu_ready", 64'(fpu_ready), 64'(expSrc == 2'd1));
      tick();
      checkOutput("starve_src", 64'(wb_src), 64'(expSrc));
      if (c == 4) checkOutput("starve_cnt_first", 64'(perf_starve_cnt), 64'd1);
    end
    idle();
    checkOutput("starve_cnt_end", 64'(perf_starve_cnt), 64'd2);
    checkOutput("starve_conflict_cnt", 64'(perf_conflict_cnt), 64'd14);
    tick();

    // x0 suppression for integer file; f0 written normally
    applyStimulus(1, 5'd0, 32'h00000055, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0_ready", 64'(int_ready), 64'd1);
    tick();
    applyStimulus(1, 5'd0, 32'h00000066, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_we", 64'(wb_reg_write), 64'd0);
    checkOutput("x0_src", 64'(wb_src), 64'd0);
    checkOutput("x0_fpwe", 64'(wb_fp_reg_write), 64'd0);
    tick();
    idle();
    checkOutput("f0_we", 64'(wb_reg_write), 64'd1);
    checkOutput("f0_fpwe", 64'(wb_fp_reg_write), 64'd1);
    checkOutput("f0_rd", 64'(wb_rd), 64'd0);
    checkOutput("f0_data", 64'(wb_data), 64'h00000066);
    tick();

    // FPU result targeting the integer file (FEQ)
    applyStimulus(0, 0, 0, 0, 1, 5'd10, 32'h00000001, 0, 0, 0, 0);
    #1;
    checkOutput("feq_ready", 64'(fpu_ready), 64'd1);
    tick();
    idle();
    checkOutput("feq_we", 64'(wb_reg_write), 64'd1);
    checkOutput("feq_fpwe", 64'(wb_fp_reg_write), 64'd0);
    checkOutput("feq_rd", 64'(wb_rd), 64'd10);
    checkOutput("feq_src", 64'(wb_src), 64'd1);
    tick();

    // Async reset while a write is showing; FFT has aged two cycles beforehand
    applyStimulus(1, 5'd7, 32'h00000077, 0, 0, 0, 0, 0, 1, 5'd9, 32'h00000099);
    tick();
    tick();
    checkOutput("prereset_we", 64'(wb_reg_write), 64'd1);
    #2;
    rst = 1'b1;
    idle();
    #1;
    checkOutput("arst_we", 64'(wb_reg_write), 64'd0);
    checkOutput("arst_src", 64'(wb_src), 64'd3);
    checkOutput("arst_data", 64'(wb_data), 64'd0);
    checkOutput("arst_rd", 64'(wb_rd), 64'd0);
    checkOutput("arst_starve", 64'(perf_starve_cnt), 64'd0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 5'd1, 32'h00001234, 1, 1, 5'd2, 32'h00005678);
    #1;
    checkOutput("post_rr_fpu_ready", 64'(fpu_ready), 64'd1);
    checkOutput("post_rr_fft_ready", 64'(fft_ready), 64'd0);
    tick();
    checkOutput("post_rr_src", 64'(wb_src), 64'd1);
    // FFT age is 1 here; it must lose three more cycles before being forced
    applyStimulus(1, 5'd7, 32'h00000077, 0, 0, 0, 0, 0, 1, 5'd9, 32'h00000099);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("post_age_fft_ready", 64'(fft_ready), 64'(c == 3));
      checkOutput("post_age_int_ready", 64'(int_ready), 64'(c != 3));
      tick();
    end
    idle();
    checkOutput("post_age_src", 64'(wb_src), 64'd2);
    checkOutput("post_starve_cnt", 64'(perf_starve_cnt), 64'd1);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
